dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU load/store unit and the AXI host path.
//  Host accesses (debug load/peek of data memory) are single-cycle pulses with no backpressure.
//  A one-entry buffer absorbs each host pulse; the CPU side uses a req/gnt handshake.
//  Read data returns to the issuing requester after the memory's fixed latency, tagged by owner.
//  Anti-starvation aging guarantees host progress while the CPU runs.
// PARAMETERS
//  ADDR_W         12  word-address width of data memory
//  MEM_LAT        1   memory read latency in cycles, legal values 1..2
//  HOST_MAX_WAIT  8   cycles a pending host access may lose before it is forced to win; 0 = host always wins
//  STAT_W         16  statistics counter width (DMEM_ARB_STATS_EN only)
// PORTS
//  S_AXI_ACLK     in   1       clock
//  S_AXI_ARESETN  in   1       asynchronous active-low reset
//  cpu_running    in   1       0: host has absolute priority
//  cpu_req        in   1       CPU access request; held with fields stable until cpu_gnt
//  cpu_we         in   1       1 = write
//  cpu_addr       in   ADDR_W  word address
//  cpu_wdata      in   32      write data
//  cpu_wstrb      in   4       byte enables
//  cpu_gnt        out  1       comb.; access issued to memory this cycle
//  cpu_rvalid     out  1       CPU read data valid
//  cpu_rdata      out  32      CPU read data
//  host_wr        in   1       one-cycle host write pulse
//  host_rd        in   1       one-cycle host read pulse
//  host_addr      in   ADDR_W  host word address, sampled with the pulse
//  host_wdata     in   32      host write data, sampled with the pulse
//  host_wstrb     in   4       host byte enables, sampled with the pulse
//  host_busy      out  1       host buffer occupied
//  host_drop      out  1       one-cycle pulse; a host pulse was discarded
//  host_rvalid    out  1       host read data valid
//  host_rdata     out  32      host read data
//  mem_en         out  1       comb.; memory access this cycle
//  mem_we         out  4       comb.; byte write enables; 0 for reads
//  mem_addr       out  ADDR_W  comb.; memory address
//  mem_wdata      out  32      comb.; memory write data
//  mem_rdata      in   32      memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset values: host buffer empty; host_busy=0, host_drop=0, cpu_rvalid=0, host_rvalid=0;
//    wait counter=0; tag pipeline cleared. Comb. outputs are 0 when idle.
//  - Host capture: host_wr|host_rd with host_busy=0 loads the buffer (op, addr, wdata, wstrb).
//    host_busy=1 from the next cycle.
//  - A pulse arriving while host_busy=1 is discarded: host_drop=1 next cycle, buffer unchanged.
//  - host_wr and host_rd in the same cycle: the write is captured, the read dropped (host_drop=1).
//  - A captured host access is eligible for arbitration one cycle after capture at the earliest.
//  - host_busy clears:
//    - host write: the cycle after its grant;
//    - host read: the cycle after host_rvalid.
//    A new pulse is accepted in the same cycle host_busy reads 0.
//  - Arbitration, one access per cycle; winner selection in priority order:
//    1. host pending and cpu_running=0        -> host
//    2. host pending and wait >= HOST_MAX_WAIT -> host
//    3. cpu_req                               -> CPU (cpu_gnt=1)
//    4. host pending                          -> host
//  - Wait counter: increments each cycle the host is pending and loses; saturates at HOST_MAX_WAIT.
//    It clears on host grant.
//  - mem_en=1 in any cycle with a winner. mem_we = winner wstrb if write, else 4'b0.
//  - Read tagging: each granted read pushes {valid, owner} into a MEM_LAT-deep shift pipeline.
//    - At the pipeline tail, the owner's rvalid=1 for one cycle; rdata = mem_rdata (pass-through).
//    - Otherwise rvalid=0 and rdata=0.
//  - Writes produce no rvalid.
//  - Back-to-back reads from either requester are accepted every cycle; no bubbles are inserted.
//  - CPU must hold cpu_req until cpu_gnt. Deasserting cpu_req without a grant cancels cleanly.
//  - Asynchronous reset mid-operation discards buffered and in-flight accesses; no rvalid follows.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined adds three outputs, each STAT_W bits, saturating, reset to 0:
//    stat_cpu_gnt   CPU grants
//    stat_host_gnt  host grants
//    stat_conflict  cycles where both requesters were eligible
//  Without DMEM_ARB_STATS_EN, these ports and counters are absent; the logic is otherwise identical.
// TESTING
//  1. Host write only: host_wr, addr 0x005, data 0xDEADBEEF, wstrb 0xF, CPU idle ->
//     grant 1 cycle after capture: mem_we=0xF, mem_addr=0x005; host_busy high for 2 cycles.
//  2. CPU read 0x010 (mem holds 0x12345678), MEM_LAT=1 -> cpu_gnt same cycle;
//     next cycle cpu_rvalid=1, cpu_rdata=0x12345678, host_rvalid=0.
//  3. Aging, cpu_running=1: cpu_req held continuously, host read pending, HOST_MAX_WAIT=8 ->
//     CPU wins 8 cycles, host granted on the 9th (cpu_gnt=0 that cycle), then CPU resumes.
//  4. Overflow: host_wr while host_busy=1 -> host_drop pulses once, buffered access unchanged;
//     simultaneous host_wr+host_rd when idle -> write performed, host_drop=1.
//  5. cpu_running=0 with cpu_req and host pending -> host granted first; cpu_gnt the next cycle.
//  6. Assert S_AXI_ARESETN=0 with a read in flight (MEM_LAT=2) -> no rvalid afterwards;
//     host_busy=0. With DMEM_ARB_STATS_EN, all stat counters read 0.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: CPU req/gnt port, host pulse port and memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              cpu_running;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  logic              host_wr;
  logic              host_rd;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [3:0]        host_wstrb;
  logic              host_busy;
  logic              host_drop;
  logic              host_rvalid;
  logic [31:0]       host_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_running, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_wr, host_rd, host_addr, host_wdata, host_wstrb,
    output host_busy, host_drop, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_running, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_wr, host_rd, host_addr, host_wdata, host_wstrb,
    input  host_busy, host_drop, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU req/gnt vs. buffered host pulses with aging, owner-tagged read return.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int MEM_LAT       = 1,
  parameter int HOST_MAX_WAIT = 8,
  parameter int STAT_W        = 16
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_cpu_gnt,
  output logic [STAT_W-1:0]  stat_host_gnt,
  output logic [STAT_W-1:0]  stat_conflict
`endif
);

  localparam int WAIT_W = (HOST_MAX_WAIT < 2) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  // CAPT is the one-cycle settle slot after capture; RDW waits for the host read to return.
  typedef enum logic [1:0] {H_IDLE, H_CAPT, H_PEND, H_RDW} hst_e;

  hst_e              state_q, state_d;
  logic              hb_we_q;
  logic [ADDR_W-1:0] hb_addr_q;
  logic [31:0]       hb_wdata_q;
  logic [3:0]        hb_wstrb_q;
  logic              drop_q, drop_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [MEM_LAT-1:0] tag_vld_q, tag_own_q;

  logic host_pend, host_win, cpu_win, cap_en, rd_push, host_rv, cpu_rv, any_pulse;

  always_comb begin
    host_pend = (state_q == H_PEND);
    host_win  = host_pend && (!bus.cpu_running || (wait_q >= WAIT_MAX) || !bus.cpu_req);
    cpu_win   = bus.cpu_req && !host_win;
    rd_push   = (host_win && !hb_we_q) || (cpu_win && !bus.cpu_we);
    host_rv   = tag_vld_q[MEM_LAT-1] &&  tag_own_q[MEM_LAT-1];
    cpu_rv    = tag_vld_q[MEM_LAT-1] && !tag_own_q[MEM_LAT-1];
    any_pulse = bus.host_wr || bus.host_rd;
  end

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      H_IDLE: begin
        if (any_pulse) begin
          cap_en  = 1'b1;
          state_d = H_CAPT;
          drop_d  = bus.host_wr && bus.host_rd;
        end
      end
      H_CAPT: begin
        drop_d  = any_pulse;
        state_d = H_PEND;
      end
      H_PEND: begin
        drop_d = any_pulse;
        if (host_win) state_d = hb_we_q ? H_IDLE : H_RDW;
      end
      H_RDW: begin
        drop_d = any_pulse;
        if (host_rv) state_d = H_IDLE;
      end
      default: state_d = H_IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (host_win)                              wait_d = '0;
    else if (host_pend && (wait_q < WAIT_MAX)) wait_d = wait_q + WAIT_W'(1);
  end

  always_comb begin
    bus.cpu_gnt   = cpu_win;
    bus.mem_en    = host_win || cpu_win;
    bus.mem_we    = 4'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (host_win) begin
      bus.mem_we    = hb_we_q ? hb_wstrb_q : 4'b0;
      bus.mem_addr  = hb_addr_q;
      bus.mem_wdata = hb_wdata_q;
    end else if (cpu_win) begin
      bus.mem_we    = bus.cpu_we ? bus.cpu_wstrb : 4'b0;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
    bus.host_busy   = (state_q != H_IDLE);
    bus.host_drop   = drop_q;
    bus.host_rvalid = host_rv;
    bus.cpu_rvalid  = cpu_rv;
    bus.host_rdata  = host_rv ? bus.mem_rdata : 32'h0;
    bus.cpu_rdata   = cpu_rv  ? bus.mem_rdata : 32'h0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= H_IDLE;
      drop_q    <= 1'b0;
      wait_q    <= '0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      wait_q       <= wait_d;
      // Tag pipeline: entry MEM_LAT-1 lines up with mem_rdata of the tagged access.
      tag_vld_q[0] <= rd_push;
      tag_own_q[0] <= host_win;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  // Buffer payload is qualified by state_q, so it needs no reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (cap_en) begin
      hb_we_q    <= bus.host_wr;
      hb_addr_q  <= bus.host_addr;
      hb_wdata_q <= bus.host_wdata;
      hb_wstrb_q <= bus.host_wstrb;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stat_cpu_gnt  <= '0;
      stat_host_gnt <= '0;
      stat_conflict <= '0;
    end else begin
      if (cpu_win)                   stat_cpu_gnt  <= sat_inc(stat_cpu_gnt);
      if (host_win)                  stat_host_gnt <= sat_inc(stat_host_gnt);
      if (host_pend && bus.cpu_req)  stat_conflict <= sat_inc(stat_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: instance A (MEM_LAT=1) and instance B (MEM_LAT=2),
// each with a small behavioural data memory.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(12)) ia ();
  dmem_port_arbiter_if #(.ADDR_W(12)) ib ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] sa_cpu, sa_host, sa_conf, sb_cpu, sb_host, sb_conf;
`endif

  dmem_port_arbiter #(.ADDR_W(12), .MEM_LAT(1), .HOST_MAX_WAIT(8), .STAT_W(16)) u_dut_a (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (ia.slave)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cpu_gnt (sa_cpu), .stat_host_gnt (sa_host), .stat_conflict (sa_conf)
`endif
  );

  dmem_port_arbiter #(.ADDR_W(12), .MEM_LAT(2), .HOST_MAX_WAIT(8), .STAT_W(16)) u_dut_b (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (ib.slave)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cpu_gnt (sb_cpu), .stat_host_gnt (sb_host), .stat_conflict (sb_conf)
`endif
  );

  // Behavioural memories: A returns data 1 cycle after mem_en, B after 2.
  logic [31:0] mem_a [0:4095];
  logic [31:0] mem_b [0:4095];
  logic [31:0] rd_a_p0, rd_b_p0, rd_b_p1;

  always @(posedge clk) begin
    rd_a_p0 <= mem_a[ia.mem_addr];
    for (int k = 0; k < 4; k++)
      if (ia.mem_en && ia.mem_we[k]) mem_a[ia.mem_addr][8*k +: 8] <= ia.mem_wdata[8*k +: 8];
  end

  always @(posedge clk) begin
    rd_b_p0 <= mem_b[ib.mem_addr];
    rd_b_p1 <= rd_b_p0;
    for (int k = 0; k < 4; k++)
      if (ib.mem_en && ib.mem_we[k]) mem_b[ib.mem_addr][8*k +: 8] <= ib.mem_wdata[8*k +: 8];
  end

  assign ia.mem_rdata = rd_a_p0;
  assign ib.mem_rdata = rd_b_p1;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ia.cpu_running = 1'b1; ia.cpu_req = 1'b0; ia.cpu_we = 1'b0; ia.cpu_addr = '0;
    ia.cpu_wdata = '0; ia.cpu_wstrb = '0;
    ia.host_wr = 1'b0; ia.host_rd = 1'b0; ia.host_addr = '0; ia.host_wdata = '0; ia.host_wstrb = '0;
    ib.cpu_running = 1'b1; ib.cpu_req = 1'b0; ib.cpu_we = 1'b0; ib.cpu_addr = '0;
    ib.cpu_wdata = '0; ib.cpu_wstrb = '0;
    ib.host_wr = 1'b0; ib.host_rd = 1'b0; ib.host_addr = '0; ib.host_wdata = '0; ib.host_wstrb = '0;
    repeat (3) tick();
    neg();
    check_vec("rst_busy",   ia.host_busy,   0);
    check_vec("rst_drop",   ia.host_drop,   0);
    check_vec("rst_crv",    ia.cpu_rvalid,  0);
    check_vec("rst_hrv",    ia.host_rvalid, 0);
    check_vec("rst_mem_en", ia.mem_en,      0);
    tick();
    rst_n = 1'b1;
    tick();

    // Host write 0xDEADBEEF to 0x005, CPU idle
    ia.host_wr = 1'b1; ia.host_addr = 12'h005; ia.host_wdata = 32'hDEADBEEF; ia.host_wstrb = 4'hF;
    neg(); check_vec("t1_busy_c0", ia.host_busy, 0); check_vec("t1_en_c0", ia.mem_en, 0);
    tick(); ia.host_wr = 1'b0;
    neg(); check_vec("t1_busy_c1", ia.host_busy, 1); check_vec("t1_en_c1", ia.mem_en, 0);
    tick();
    neg();
    check_vec("t1_en_c2",    ia.mem_en,    1);
    check_vec("t1_we_c2",    ia.mem_we,    4'hF);
    check_vec("t1_addr_c2",  ia.mem_addr,  12'h005);
    check_vec("t1_wdata_c2", ia.mem_wdata, 32'hDEADBEEF);
    check_vec("t1_busy_c2",  ia.host_busy, 1);
    check_vec("t1_gnt_c2",   ia.cpu_gnt,   0);
    tick();
    neg(); check_vec("t1_busy_c3", ia.host_busy, 0); check_vec("t1_en_c3", ia.mem_en, 0);
    tick();

    // CPU write then read of 0x010
    ia.cpu_req = 1'b1; ia.cpu_we = 1'b1; ia.cpu_addr = 12'h010; ia.cpu_wdata = 32'h12345678; ia.cpu_wstrb = 4'hF;
    neg(); check_vec("t2_wgnt", ia.cpu_gnt, 1); check_vec("t2_wwe", ia.mem_we, 4'hF);
    tick(); ia.cpu_we = 1'b0;
    neg(); check_vec("t2_rgnt", ia.cpu_gnt, 1); check_vec("t2_rwe", ia.mem_we, 0);
    tick(); ia.cpu_req = 1'b0;
    neg();
    check_vec("t2_crv",   ia.cpu_rvalid,  1);
    check_vec("t2_crd",   ia.cpu_rdata,   32'h12345678);
    check_vec("t2_hrv",   ia.host_rvalid, 0);
    tick();
    neg(); check_vec("t2_crv_off", ia.cpu_rvalid, 0); check_vec("t2_crd_off", ia.cpu_rdata, 0);
    tick();

    // Partial-strobe CPU write: 0x12345678 becomes 0x12BBCC78
    ia.cpu_req = 1'b1; ia.cpu_we = 1'b1; ia.cpu_wdata = 32'hAABBCCDD; ia.cpu_wstrb = 4'h6;
    neg(); check_vec("t2_pwe", ia.mem_we, 4'h6);
    tick(); ia.cpu_req = 1'b0; ia.cpu_we = 1'b0;

    // Host read of 0x005
    ia.host_rd = 1'b1; ia.host_addr = 12'h005;
    neg(); tick(); ia.host_rd = 1'b0;
    neg(); check_vec("hr_busy_c1", ia.host_busy, 1);
    tick();
    neg(); check_vec("hr_en_c2", ia.mem_en, 1); check_vec("hr_we_c2", ia.mem_we, 0);
    check_vec("hr_addr_c2", ia.mem_addr, 12'h005);
    tick();
    neg();
    check_vec("hr_hrv_c3",  ia.host_rvalid, 1);
    check_vec("hr_hrd_c3",  ia.host_rdata,  32'hDEADBEEF);
    check_vec("hr_busy_c3", ia.host_busy,   1);
    check_vec("hr_crv_c3",  ia.cpu_rvalid,  0);
    tick();
    neg(); check_vec("hr_busy_c4", ia.host_busy, 0); check_vec("hr_hrv_c4", ia.host_rvalid, 0);
    tick();

    // Aging: CPU reads held, host read pending
    ia.cpu_running = 1'b1; ia.cpu_req = 1'b1; ia.cpu_we = 1'b0; ia.cpu_addr = 12'h010;
    ia.host_rd = 1'b1; ia.host_addr = 12'h005;
    neg(); check_vec("t3_gnt_c0", ia.cpu_gnt, 1);
    tick(); ia.host_rd = 1'b0;
    neg(); check_vec("t3_gnt_c1", ia.cpu_gnt, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      neg(); check_vec($sformatf("t3_gnt_lose%0d", i), ia.cpu_gnt, 1);
      tick();
    end
    neg(); check_vec("t3_gnt_age", ia.cpu_gnt, 0); check_vec("t3_addr_age", ia.mem_addr, 12'h005);
    tick();
    neg();
    check_vec("t3_gnt_resume", ia.cpu_gnt,     1);
    check_vec("t3_hrv",        ia.host_rvalid, 1);
    check_vec("t3_hrd",        ia.host_rdata,  32'hDEADBEEF);
    tick(); ia.cpu_req = 1'b0;
    neg();
    check_vec("t3_busy_end", ia.host_busy,  0);
    check_vec("t3_crv_end",  ia.cpu_rvalid, 1);
    check_vec("t3_crd_end",  ia.cpu_rdata,  32'h12BBCC78);
    tick();

    // Overflow while busy
    ia.host_wr = 1'b1; ia.host_addr = 12'h020; ia.host_wdata = 32'hA5A5A5A5; ia.host_wstrb = 4'hF;
    neg(); tick();
    ia.host_addr = 12'h021; ia.host_wdata = 32'h11111111;
    neg(); check_vec("t4_drop_c1", ia.host_drop, 0);
    tick(); ia.host_wr = 1'b0;
    neg();
    check_vec("t4_drop_c2",  ia.host_drop, 1);
    check_vec("t4_en_c2",    ia.mem_en,    1);
    check_vec("t4_addr_c2",  ia.mem_addr,  12'h020);
    check_vec("t4_wdata_c2", ia.mem_wdata, 32'hA5A5A5A5);
    tick();
    neg(); check_vec("t4_drop_c3", ia.host_drop, 0); check_vec("t4_busy_c3", ia.host_busy, 0);
    tick();

    // Simultaneous write + read when idle
    ia.host_wr = 1'b1; ia.host_rd = 1'b1; ia.host_addr = 12'h022; ia.host_wdata = 32'h5A5A5A5A; ia.host_wstrb = 4'hF;
    neg(); tick(); ia.host_wr = 1'b0; ia.host_rd = 1'b0;
    neg(); check_vec("t4s_drop", ia.host_drop, 1); check_vec("t4s_busy", ia.host_busy, 1);
    tick();
    neg(); check_vec("t4s_en", ia.mem_en, 1); check_vec("t4s_we", ia.mem_we, 4'hF);
    check_vec("t4s_addr", ia.mem_addr, 12'h022);
    tick();
    neg(); check_vec("t4s_busy_end", ia.host_busy, 0); check_vec("t4s_drop_end", ia.host_drop, 0);
    tick();

    // cpu_running=0: host has absolute priority
    ia.cpu_running = 1'b0; ia.host_rd = 1'b1; ia.host_addr = 12'h020;
    neg(); tick(); ia.host_rd = 1'b0;
    neg(); tick();
    ia.cpu_req = 1'b1; ia.cpu_we = 1'b0; ia.cpu_addr = 12'h022;
    neg(); check_vec("t5_gnt_c2", ia.cpu_gnt, 0); check_vec("t5_addr_c2", ia.mem_addr, 12'h020);
    tick();
    neg();
    check_vec("t5_gnt_c3",  ia.cpu_gnt,     1);
    check_vec("t5_addr_c3", ia.mem_addr,    12'h022);
    check_vec("t5_hrv_c3",  ia.host_rvalid, 1);
    check_vec("t5_hrd_c3",  ia.host_rdata,  32'hA5A5A5A5);
    tick(); ia.cpu_req = 1'b0; ia.cpu_running = 1'b1;
    neg(); check_vec("t5_crv_c4", ia.cpu_rvalid, 1); check_vec("t5_crd_c4", ia.cpu_rdata, 32'h5A5A5A5A);
    tick();

    // Instance B, MEM_LAT=2: normal read latency
    ib.cpu_req = 1'b1; ib.cpu_we = 1'b1; ib.cpu_addr = 12'h030; ib.cpu_wdata = 32'hCAFEF00D; ib.cpu_wstrb = 4'hF;
    neg(); check_vec("t6_wgnt", ib.cpu_gnt, 1);
    tick(); ib.cpu_we = 1'b0;
    neg(); check_vec("t6_rgnt", ib.cpu_gnt, 1);
    tick(); ib.cpu_req = 1'b0;
    neg(); check_vec("t6_crv_l1", ib.cpu_rvalid, 0);
    tick();
    neg(); check_vec("t6_crv_l2", ib.cpu_rvalid, 1); check_vec("t6_crd_l2", ib.cpu_rdata, 32'hCAFEF00D);
    tick();

    // Reset with a read in flight and a host access buffered
    ib.cpu_req = 1'b1; ib.host_rd = 1'b1; ib.host_addr = 12'h030;
    neg(); check_vec("t6_gnt_pre", ib.cpu_gnt, 1);
    tick(); ib.cpu_req = 1'b0; ib.host_rd = 1'b0;
    rst_n = 1'b0;
    #1;
    check_vec("t6_busy_rst", ib.host_busy,  0);
    check_vec("t6_crv_rst",  ib.cpu_rvalid, 0);
    neg(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      neg();
      check_vec($sformatf("t6_crv_post%0d", i), ib.cpu_rvalid,  0);
      check_vec($sformatf("t6_hrv_post%0d", i), ib.host_rvalid, 0);
      check_vec($sformatf("t6_busy_post%0d", i), ib.host_busy,  0);
      tick();
    end
`ifdef DMEM_ARB_STATS_EN
    check_vec("t6_stat_cpu",  sb_cpu,  0);
    check_vec("t6_stat_host", sb_host, 0);
    check_vec("t6_stat_conf", sb_conf, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
